// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results and queued LSU results share one write port.
// Optional feature macro: WB_ANTISTARVE_EN (bounded LSU starvation via a forced grant).
module writeback_arbiter #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [4:0]        alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [4:0]        lsu_rd_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              reg_wr_en_o,
    output logic [4:0]        rd_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [31:0]       busy_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]        r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_force;
    logic              w_alu_grant;
    logic              w_pop;
    logic              w_push;
    logic [4:0]        w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic [31:0]       w_busy;

    // Ready depends on the registered count only, so a full FIFO never accepts even when popping.
    assign lsu_ready_o = (r_count < CW'(DEPTH));
    assign w_push      = lsu_valid_i && lsu_ready_o && !flush_i;

    assign alu_ready_o = !w_force;
    assign w_alu_grant = alu_valid_i && !w_force;
    assign w_pop       = !w_alu_grant && (r_count != '0) && !flush_i;

    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

`ifdef WB_ANTISTARVE_EN
    localparam int SW = $clog2(STALL_MAX + 1);
    logic [SW-1:0] r_stall;

    assign w_force = (r_stall == SW'(STALL_MAX)) && (r_count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall <= '0;
        end else if ((r_count == '0) || w_pop || flush_i) begin
            r_stall <= '0;
        end else if (w_alu_grant && (r_stall != SW'(STALL_MAX))) begin
            r_stall <= r_stall + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= lsu_rd_i;
            r_fifo_data[r_wptr] <= lsu_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_wr_en_o <= 1'b0;
            rd_addr_o   <= '0;
            wr_data_o   <= '0;
        end else if (w_alu_grant) begin
            reg_wr_en_o <= (alu_rd_i != 5'd0);
            rd_addr_o   <= alu_rd_i;
            wr_data_o   <= alu_data_i;
        end else if (w_pop) begin
            reg_wr_en_o <= (w_head_rd != 5'd0);
            rd_addr_o   <= w_head_rd;
            wr_data_o   <= w_head_data;
        end else begin
            reg_wr_en_o <= 1'b0;
        end
    end

    // Busy map covers only the live window [rptr, rptr+count) of the FIFO.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(r_count)) begin
                w_busy[r_fifo_rd[r_rptr + PW'(i)]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy_o = w_busy;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-level reference model checked every cycle.
module tb_writeback_arbiter;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int STALL_MAX = 8;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              reg_wr_en;
  logic [4:0]        rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       busy;

  int n_cmp = 0;
  int n_err = 0;

  writeback_arbiter #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .STALL_MAX(STALL_MAX)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .alu_valid_i(alu_valid),
    .alu_ready_o(alu_ready),
    .alu_rd_i   (alu_rd),
    .alu_data_i (alu_data),
    .lsu_valid_i(lsu_valid),
    .lsu_ready_o(lsu_ready),
    .lsu_rd_i   (lsu_rd),
    .lsu_data_i (lsu_data),
    .reg_wr_en_o(reg_wr_en),
    .rd_addr_o  (rd_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the LSU FIFO is a queue of {rd, data}; outputs follow from the grant rules.
  logic [36:0]       exp_q[$];
  logic              m_wr_en = 1'b0;
  logic [4:0]        m_rd    = '0;
  logic [DATA_W-1:0] m_data  = '0;
  int                m_stall = 0;
  logic              m_alu_win, m_lsu_win, m_full, m_was_empty;
  logic [36:0]       m_head;

  function automatic logic m_forced();
    logic f;
    f = 1'b0;
`ifdef WB_ANTISTARVE_EN
    f = (m_stall == STALL_MAX) && (exp_q.size() != 0);
`endif
    return f;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    foreach (exp_q[i]) b[exp_q[i][36:32]] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_wr_en = 1'b0;
      m_rd    = '0;
      m_data  = '0;
      m_stall = 0;
    end else begin
      m_was_empty = (exp_q.size() == 0);
      m_full      = (exp_q.size() == DEPTH);
      m_alu_win   = alu_valid && !m_forced();
      m_lsu_win   = !m_alu_win && !m_was_empty && !flush;
      if (m_alu_win) begin
        m_wr_en = (alu_rd != 0);
        m_rd    = alu_rd;
        m_data  = alu_data;
      end else if (m_lsu_win) begin
        m_head  = exp_q.pop_front();
        m_wr_en = (m_head[36:32] != 0);
        m_rd    = m_head[36:32];
        m_data  = m_head[31:0];
      end else begin
        m_wr_en = 1'b0;
      end
      if (m_was_empty || m_lsu_win || flush) m_stall = 0;
      else if (m_alu_win && m_stall < STALL_MAX) m_stall = m_stall + 1;
      if (flush) exp_q.delete();
      else if (lsu_valid && !m_full) exp_q.push_back({lsu_rd, lsu_data});
    end
  end

  // Scoreboard compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    check("cmp_lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_q.size() < DEPTH});
    check("cmp_alu_ready", {31'd0, alu_ready}, {31'd0, !m_forced()});
    check("cmp_busy",      busy,               m_busy());
    check("cmp_wr_en",     {31'd0, reg_wr_en}, {31'd0, m_wr_en});
    check("cmp_rd_addr",   {27'd0, rd_addr},   {27'd0, m_rd});
    check("cmp_wr_data",   wr_data,            m_data);
  end

  // driver
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic fl);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  int drop_n;

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    rst = 1'b0;
    idle();

    // ALU single result
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    check("alu_wr_en", {31'd0, reg_wr_en}, 32'd1);
    check("alu_rd", {27'd0, rd_addr}, 32'd5);
    check("alu_data", wr_data, 32'hDEADBEEF);
    idle();
    check("alu_wr_en_off", {31'd0, reg_wr_en}, 32'd0);
    check("alu_rd_hold", {27'd0, rd_addr}, 32'd5);

    // Fill the FIFO behind ALU traffic, then drain in order
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 5'(9 + i), 32'h900 + i, 1'b1, 5'(i), 32'h100 + i, 1'b0);
    check("fill_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    check("fill_busy_peak", busy, 32'h0000001E);
    drive(1'b1, 5'd14, 32'h90E, 1'b1, 5'd7, 32'h777, 1'b0);
    check("full_busy_no_push", busy, 32'h0000001E);
    for (int i = 1; i <= 4; i++) begin
      idle();
      check("drain_wr_en", {31'd0, reg_wr_en}, 32'd1);
      check("drain_rd", {27'd0, rd_addr}, i);
      check("drain_data", wr_data, 32'h100 + i);
    end
    check("drain_busy", busy, 32'd0);
    idle();
    check("drain_done_wr_en", {31'd0, reg_wr_en}, 32'd0);

    // Load to x0: handshake completes, no write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
    check("x0_push_ready", {31'd0, lsu_ready}, 32'd1);
    idle();
    check("x0_no_write", {31'd0, reg_wr_en}, 32'd0);
    check("x0_data_taken", wr_data, 32'h1234);
    idle();

    // Fill then flush together with a push
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'd11, 32'hB00 + i, 1'b1, 5'(6 + i), 32'h600 + i, 1'b0);
    check("pre_flush_busy", busy, 32'h000003C0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF, 1'b1);
    check("flush_busy", busy, 32'd0);
    check("flush_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("flush_wr_en", {31'd0, reg_wr_en}, 32'd0);
    repeat (3) begin
      idle();
      check("post_flush_no_write", {31'd0, reg_wr_en}, 32'd0);
    end

`ifdef WB_ANTISTARVE_EN
    // Starvation bound: one load behind a continuous ALU stream
    drive(1'b1, 5'd3, 32'h500, 1'b1, 5'd20, 32'hABCD, 1'b0);
    drop_n = -1;
    for (int k = 0; k < 12; k++) begin
      if (alu_ready === 1'b0 && drop_n < 0) drop_n = k;
      drive(1'b1, 5'd3, 32'h500, 1'b0, 5'd0, 32'd0, 1'b0);
      if (k == drop_n) begin
        check("as_load_en", {31'd0, reg_wr_en}, 32'd1);
        check("as_load_rd", {27'd0, rd_addr}, 32'd20);
      end
      if (drop_n >= 0 && k == drop_n + 1)
        check("as_alu_resume", {27'd0, rd_addr}, 32'd3);
    end
    check("as_drop_cycle", drop_n, STALL_MAX);
    idle();
`endif

    // Asynchronous reset mid-stream
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b0);
    drive(1'b1, 5'd7, 32'h78, 1'b1, 5'd10, 32'h9A, 1'b0);
    check("pre_rst_wr_en", {31'd0, reg_wr_en}, 32'd1);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check("async_rst_busy", busy, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (5) begin
      idle();
      check("post_rst_no_write", {31'd0, reg_wr_en}, 32'd0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
